// File: rtl/press_queue_pkg.sv
// press_queue_pkg: shared constants, event entry type and index-width helper
// for the press_queue block. Optional release tracking is enabled by defining
// PRESS_QUEUE_REL_EVENT_EN when compiling press_queue.
package press_queue_pkg;

  localparam int NUM_BUTTONS_DEF = 4;
  localparam int FIFO_DEPTH_DEF  = 4;

  // Width of a button index: at least one bit, even for a single button.
  function automatic int idx_width(input int num_buttons);
    int w;
    w = $clog2(num_buttons);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int IDX_W_DEF = idx_width(NUM_BUTTONS_DEF);

  // Queue entry layout for the default configuration; the release flag sits
  // above the index, matching how press_queue packs entries into the FIFO.
  typedef struct packed {
    logic                 rel;
    logic [IDX_W_DEF-1:0] index;
  } evt_entry_t;

endpackage

// File: rtl/press_queue_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through queue. The head entry is
// read combinationally from storage; a push into a full queue is accepted
// only when the head is popped in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy update; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write.
  // NOTE: the data array has no reset; empty/count already hide stale contents,
  // and leaving it unreset lets it map onto plain RAM/flop arrays without reset muxes.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/press_queue.sv
// press_queue: detects button press edges (and, with PRESS_QUEUE_REL_EVENT_EN
// defined, release edges), holds them in pending masks and drains them one per
// cycle, lowest index first, into a FWFT event queue.
module press_queue
  import press_queue_pkg::*;
#(
  parameter int NUM_BUTTONS = NUM_BUTTONS_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  localparam int IDX_W      = idx_width(NUM_BUTTONS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [IDX_W-1:0]       evt_index,
  output logic                   evt_release,
  output logic                   overflow
);

`ifdef PRESS_QUEUE_REL_EVENT_EN
  // Request vector: presses in the low half, releases in the high half, so the
  // lowest-set-bit arbiter serves every press before any release.
  localparam int REQ_W   = 2 * NUM_BUTTONS;
  localparam int ENTRY_W = IDX_W + 1;
`else
  localparam int REQ_W   = NUM_BUTTONS;
  localparam int ENTRY_W = IDX_W;
`endif

  logic [NUM_BUTTONS-1:0] prev;
  logic [REQ_W-1:0]       pending;
  logic [REQ_W-1:0]       edges;
  logic [REQ_W-1:0]       first;
  logic [REQ_W-1:0]       grant;
  logic                   found;
  int                     sel;
  logic                   can_push;
  logic                   push;
  logic [ENTRY_W-1:0]     push_entry;
  logic [ENTRY_W-1:0]     head_entry;
  logic                   fifo_full;
  logic                   fifo_empty;

`ifdef PRESS_QUEUE_REL_EVENT_EN
  // Set for the first cycle after reset: prev is all ones then, so every idle
  // button would otherwise look like a release.
  logic fresh;

  assign edges = {~buttons & prev & {NUM_BUTTONS{~fresh}}, buttons & ~prev};

  // Suppress release detection until prev has sampled real button levels.
  always_ff @(posedge clk) begin
    if (reset) fresh <= 1'b1;
    else       fresh <= 1'b0;
  end
`else
  assign edges = buttons & ~prev;
`endif

  // Lowest-index pending request wins.
  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first, so no path can leave a value held and infer a latch.
  always_comb begin
    found = 1'b0;
    first = '0;
    sel   = 0;
    for (int i = 0; i < REQ_W; i++) begin
      if (pending[i] && !found) begin
        found    = 1'b1;
        first[i] = 1'b1;
        sel      = i;
      end
    end
  end

  // A full queue still accepts an entry when its head leaves this cycle.
  assign can_push = ~fifo_full | (evt_valid & evt_ready);
  assign push     = found & can_push;
  assign grant    = push ? first : '0;

`ifdef PRESS_QUEUE_REL_EVENT_EN
  assign push_entry  = {(sel >= NUM_BUTTONS), IDX_W'(sel % NUM_BUTTONS)};
  assign evt_release = head_entry[IDX_W];
`else
  assign push_entry  = IDX_W'(sel);
  assign evt_release = 1'b0;
`endif

  assign evt_index = head_entry[IDX_W-1:0];
  assign evt_valid = ~fifo_empty;

  // Edge history, pending masks and sticky overflow. A new edge re-sets a bit
  // being granted this cycle; an edge on a bit still waiting is lost.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= '1;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      prev    <= buttons;
      pending <= (pending & ~grant) | edges;
      if (|(edges & pending & ~grant)) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_entry),
    .full  (fifo_full),
    .pop   (evt_ready),
    .dout  (head_entry),
    .empty (fifo_empty)
  );

endmodule
